// File: rtl/count_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// count_pkg : shared types and constants for the counter wrap tracker
// Revision  : 1.0
// ----------------------------------------------------------------------------
package count_pkg;

  localparam int CNT_W_DEF = 3;
  localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    TRACK      = 2'd1,
    FAULT      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DN      = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

endpackage
`default_nettype wire

// File: rtl/count_step_classify.sv
`default_nettype none
// ----------------------------------------------------------------------------
// count_step_classify : classifies one counter step (prev -> cnt) and flags wraps
// Revision            : 1.0
// ----------------------------------------------------------------------------
module count_step_classify
  import count_pkg::*;
#(
  parameter int               CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX   = CNT_W'(CNT_MAX)
) (
  input  logic [CNT_W-1:0] i_prev,
  input  logic [CNT_W-1:0] i_cnt,
  output step_t            o_step,
  output logic             o_wrap
);

  logic [CNT_W-1:0] w_diff;

  // Modulo difference: +1 and -1 (all ones) are the only legal moves.
  always_comb begin
    w_diff = i_cnt - i_prev;
    o_step = STEP_ILLEGAL;
    o_wrap = 1'b0;
    if (w_diff == '0) begin
      o_step = STEP_HOLD;
    end else if (w_diff == CNT_W'(1)) begin
      o_step = STEP_UP;
      o_wrap = (i_prev == MAX);
    end else if (w_diff == MAX) begin
      o_step = STEP_DN;
      o_wrap = (i_prev == '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/count_wrap_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// count_wrap_tracker : tracks direction, laps and illegal steps of a narrow counter
// Revision           : 1.0
// ----------------------------------------------------------------------------
module count_wrap_tracker
  import count_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LAP_W = 8,
  parameter int ERR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   cnt_valid,
  input  logic                   clr,
  output logic                   dir_up,
  output logic                   wrap_up,
  output logic                   wrap_dn,
  output logic [LAP_W-1:0]       lap_count,
  output logic [LAP_W+CNT_W-1:0] ext_count,
  output logic                   lap_ovf,
  output logic                   err,
  output logic [ERR_W-1:0]       err_count
);

  localparam logic [LAP_W-1:0] c_lap_pos_max = {1'b0, {(LAP_W-1){1'b1}}};
  localparam logic [LAP_W-1:0] c_lap_neg_min = {1'b1, {(LAP_W-1){1'b0}}};
  localparam logic [ERR_W-1:0] c_err_sat     = '1;
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_prev;
  step_t            w_step;
  logic             w_wrap;

  count_step_classify #(
    .CNT_W (CNT_W),
    .MAX   (c_cnt_max)
  ) u_classify (
    .i_prev (r_prev),
    .i_cnt  (cnt_in),
    .o_step (w_step),
    .o_wrap (w_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= WAIT_FIRST;
      r_prev    <= '0;
      dir_up    <= 1'b1;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      lap_count <= '0;
      lap_ovf   <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else if (clr) begin
      r_state   <= WAIT_FIRST;
      r_prev    <= '0;
      dir_up    <= 1'b1;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      lap_count <= '0;
      lap_ovf   <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      if (cnt_valid) begin
        r_prev <= cnt_in;
        case (r_state)
          WAIT_FIRST: r_state <= TRACK;
          TRACK: begin
            case (w_step)
              STEP_UP: begin
                dir_up <= 1'b1;
                if (w_wrap) begin
                  wrap_up   <= 1'b1;
                  lap_count <= lap_count + LAP_W'(1);
                  if (lap_count == c_lap_pos_max) lap_ovf <= 1'b1;
                end
              end
              STEP_DN: begin
                dir_up <= 1'b0;
                if (w_wrap) begin
                  wrap_dn   <= 1'b1;
                  lap_count <= lap_count - LAP_W'(1);
                  if (lap_count == c_lap_neg_min) lap_ovf <= 1'b1;
                end
              end
              STEP_ILLEGAL: begin
                err     <= 1'b1;
                r_state <= FAULT;
                if (err_count != c_err_sat) err_count <= err_count + ERR_W'(1);
              end
              default: ;
            endcase
          end
          // FAULT only tracks the sample; exit is via clr or reset.
          default: ;
        endcase
      end
    end
  end

  assign ext_count = {lap_count, r_prev};

endmodule
`default_nettype wire

// File: tb/tb_count_wrap_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_count_wrap_tracker : scoreboard bench for count_wrap_tracker
// Revision              : 1.0
// ----------------------------------------------------------------------------
module tb_count_wrap_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cnt_valid = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  cnt_in = 3'd0;
  logic        dir_up, wrap_up, wrap_dn, lap_ovf, err;
  logic [7:0]  lap_count, err_count;
  logic [10:0] ext_count;

  int n_cmp = 0;
  int n_bad = 0;

  // care bits: 0 dir_up, 1 wrap_up, 2 wrap_dn, 3 lap, 4 ext, 5 ovf, 6 err, 7 err_count
  typedef struct {
    string       name;
    logic [7:0]  care;
    logic        du, wu, wd;
    logic [7:0]  lap;
    logic [10:0] ext;
    logic        ovf, er;
    logic [7:0]  ec;
  } exp_t;

  localparam logic [7:0] ALL = 8'hFF;

  exp_t q[$];

  always #5 clk = ~clk;

  count_wrap_tracker #(.CNT_W(3), .LAP_W(8), .ERR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .clr       (clr),
    .dir_up    (dir_up),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .lap_count (lap_count),
    .ext_count (ext_count),
    .lap_ovf   (lap_ovf),
    .err       (err),
    .err_count (err_count)
  );

  function automatic exp_t mk(string n, logic [7:0] care, logic du, logic wu, logic wd,
                              logic [7:0] lap, logic [10:0] ext, logic ovf, logic er,
                              logic [7:0] ec);
    exp_t e;
    e.name = n; e.care = care; e.du = du; e.wu = wu; e.wd = wd;
    e.lap = lap; e.ext = ext; e.ovf = ovf; e.er = er; e.ec = ec;
    return e;
  endfunction

  function automatic exp_t rst_exp(string n);
    return mk(n, ALL, 1'b1, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0, 8'h00);
  endfunction

  function automatic exp_t nc();
    return mk("nc", 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 11'h000, 1'b0, 1'b0, 8'h00);
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", n, act, want);
    end
  endtask

  task automatic check_all(exp_t e);
    if (e.care[0]) chk({e.name, ".dir_up"},    32'(dir_up),    32'(e.du));
    if (e.care[1]) chk({e.name, ".wrap_up"},   32'(wrap_up),   32'(e.wu));
    if (e.care[2]) chk({e.name, ".wrap_dn"},   32'(wrap_dn),   32'(e.wd));
    if (e.care[3]) chk({e.name, ".lap_count"}, 32'(lap_count), 32'(e.lap));
    if (e.care[4]) chk({e.name, ".ext_count"}, 32'(ext_count), 32'(e.ext));
    if (e.care[5]) chk({e.name, ".lap_ovf"},   32'(lap_ovf),   32'(e.ovf));
    if (e.care[6]) chk({e.name, ".err"},       32'(err),       32'(e.er));
    if (e.care[7]) chk({e.name, ".err_count"}, 32'(err_count), 32'(e.ec));
  endtask

  // Monitor: every registered response is checked shortly after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) check_all(q.pop_front());
    end
  end

  task automatic cyc(logic v, logic [2:0] c, logic cl, exp_t e);
    @(negedge clk);
    cnt_valid = v;
    cnt_in    = c;
    clr       = cl;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #2 check_all(rst_exp("reset"));
    @(negedge clk);
    rst = 1'b1;

    // Up run with one wrap
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 3'(i), 1'b0, mk($sformatf("up%0d", i), ALL, 1, 0, 0, 8'h00, 11'(i), 0, 0, 8'h00));
    cyc(1'b1, 3'd0, 1'b0, mk("up_wrap",  ALL, 1, 1, 0, 8'h01, 11'h008, 0, 0, 8'h00));
    cyc(1'b1, 3'd1, 1'b0, mk("up_after", ALL, 1, 0, 0, 8'h01, 11'h009, 0, 0, 8'h00));

    // Down wrap
    cyc(1'b0, 3'd0, 1'b1, rst_exp("clr1"));
    cyc(1'b1, 3'd0, 1'b0, mk("dn_cap",   ALL, 1, 0, 0, 8'h00, 11'h000, 0, 0, 8'h00));
    cyc(1'b1, 3'd7, 1'b0, mk("dn_wrap",  ALL, 0, 0, 1, 8'hFF, 11'h7FF, 0, 0, 8'h00));
    cyc(1'b1, 3'd6, 1'b0, mk("dn_after", ALL, 0, 0, 0, 8'hFF, 11'h7FE, 0, 0, 8'h00));
    cyc(1'b0, 3'd6, 1'b0, mk("dn_gap",   ALL, 0, 0, 0, 8'hFF, 11'h7FE, 0, 0, 8'h00));

    // Illegal jump, FAULT behaviour, clr beating a valid sample
    cyc(1'b0, 3'd0, 1'b1, rst_exp("clr2"));
    cyc(1'b1, 3'd2, 1'b0, mk("ill_cap",  ALL, 1, 0, 0, 8'h00, 11'h002, 0, 0, 8'h00));
    cyc(1'b1, 3'd5, 1'b0, mk("ill_jump", ALL, 1, 0, 0, 8'h00, 11'h005, 0, 1, 8'h01));
    cyc(1'b1, 3'd6, 1'b0, mk("flt6",     ALL, 1, 0, 0, 8'h00, 11'h006, 0, 1, 8'h01));
    cyc(1'b1, 3'd7, 1'b0, mk("flt7",     ALL, 1, 0, 0, 8'h00, 11'h007, 0, 1, 8'h01));
    cyc(1'b1, 3'd0, 1'b0, mk("flt0",     ALL, 1, 0, 0, 8'h00, 11'h000, 0, 1, 8'h01));
    cyc(1'b1, 3'd4, 1'b0, mk("flt_jump", ALL, 1, 0, 0, 8'h00, 11'h004, 0, 1, 8'h01));
    cyc(1'b1, 3'd3, 1'b1, rst_exp("clr_valid"));
    cyc(1'b1, 3'd5, 1'b0, mk("recap",    ALL, 1, 0, 0, 8'h00, 11'h005, 0, 0, 8'h00));

    // Holds and gaps
    cyc(1'b1, 3'd4, 1'b0, mk("h_dn4",   ALL, 0, 0, 0, 8'h00, 11'h004, 0, 0, 8'h00));
    cyc(1'b1, 3'd3, 1'b0, mk("h_dn3",   ALL, 0, 0, 0, 8'h00, 11'h003, 0, 0, 8'h00));
    cyc(1'b0, 3'd0, 1'b0, mk("h_gap1",  ALL, 0, 0, 0, 8'h00, 11'h003, 0, 0, 8'h00));
    cyc(1'b1, 3'd3, 1'b0, mk("h_hold1", ALL, 0, 0, 0, 8'h00, 11'h003, 0, 0, 8'h00));
    cyc(1'b0, 3'd7, 1'b0, mk("h_gap2",  ALL, 0, 0, 0, 8'h00, 11'h003, 0, 0, 8'h00));
    cyc(1'b1, 3'd3, 1'b0, mk("h_hold2", ALL, 0, 0, 0, 8'h00, 11'h003, 0, 0, 8'h00));

    // Positive lap overflow
    cyc(1'b0, 3'd0, 1'b1, rst_exp("clr3"));
    cyc(1'b1, 3'd0, 1'b0, mk("ov_cap", ALL, 1, 0, 0, 8'h00, 11'h000, 0, 0, 8'h00));
    for (int k = 1; k <= 127; k++) begin
      for (int s = 1; s < 8; s++) cyc(1'b1, 3'(s), 1'b0, nc());
      cyc(1'b1, 3'd0, 1'b0, mk($sformatf("ov_lap%0d", k), 8'h3A, 0, 1, 0, 8'(k),
                               {8'(k), 3'd0}, 0, 0, 8'h00));
    end
    for (int s = 1; s < 8; s++) cyc(1'b1, 3'(s), 1'b0, nc());
    cyc(1'b1, 3'd0, 1'b0, mk("ov_lap128", ALL, 1, 1, 0, 8'h80, 11'h400, 1, 0, 8'h00));
    cyc(1'b0, 3'd0, 1'b0, mk("ov_gap",    ALL, 1, 0, 0, 8'h80, 11'h400, 1, 0, 8'h00));
    cyc(1'b1, 3'd7, 1'b0, mk("ov_dn1",    ALL, 0, 0, 1, 8'h7F, 11'h3FF, 1, 0, 8'h00));
    for (int s = 6; s >= 0; s--) cyc(1'b1, 3'(s), 1'b0, nc());
    cyc(1'b1, 3'd7, 1'b0, mk("ov_dn2",    ALL, 0, 0, 1, 8'h7E, 11'h3F7, 1, 0, 8'h00));
    cyc(1'b0, 3'd0, 1'b1, rst_exp("clr_ovf"));

    // Negative lap overflow
    cyc(1'b1, 3'd0, 1'b0, mk("uf_cap", ALL, 1, 0, 0, 8'h00, 11'h000, 0, 0, 8'h00));
    for (int k = 1; k <= 128; k++) begin
      cyc(1'b1, 3'd7, 1'b0, mk($sformatf("uf_lap%0d", k), 8'h2E, 0, 0, 1, 8'(256 - k),
                               11'h000, 0, 0, 8'h00));
      for (int s = 6; s >= 0; s--) cyc(1'b1, 3'(s), 1'b0, nc());
    end
    cyc(1'b1, 3'd7, 1'b0, mk("uf_wrap", ALL, 0, 0, 1, 8'h7F, 11'h3FF, 1, 0, 8'h00));

    // Asynchronous reset mid-run with lap_count=3 and err=1
    cyc(1'b0, 3'd0, 1'b1, rst_exp("clr4"));
    cyc(1'b1, 3'd0, 1'b0, mk("as_cap", ALL, 1, 0, 0, 8'h00, 11'h000, 0, 0, 8'h00));
    for (int k = 1; k <= 3; k++) begin
      for (int s = 1; s < 8; s++) cyc(1'b1, 3'(s), 1'b0, nc());
      cyc(1'b1, 3'd0, 1'b0, mk($sformatf("as_lap%0d", k), 8'h0A, 0, 1, 0, 8'(k),
                               11'h000, 0, 0, 8'h00));
    end
    cyc(1'b1, 3'd4, 1'b0, mk("as_err", ALL, 1, 0, 0, 8'h03, 11'h01C, 0, 1, 8'h01));
    #3 rst = 1'b0;
    #1 check_all(rst_exp("as_async"));
    @(posedge clk);
    #2 check_all(rst_exp("as_held"));
    @(negedge clk);
    rst       = 1'b1;
    cnt_valid = 1'b0;
    cyc(1'b1, 3'd5, 1'b0, mk("as_recap", ALL, 1, 0, 0, 8'h00, 11'h005, 0, 0, 8'h00));
    cyc(1'b1, 3'd4, 1'b0, mk("as_track", ALL, 0, 0, 0, 8'h00, 11'h004, 0, 0, 8'h00));

    repeat (3) @(posedge clk);
    #3;
    chk("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
